// File: rtl/turn_signal_seq_pkg.sv
// Shared mode encodings and request decode for the turn-signal sequencer.
package turn_signal_seq_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LEFT   = 2'd1;
    localparam logic [1:0] ST_RIGHT  = 2'd2;
    localparam logic [1:0] ST_HAZARD = 2'd3;

    // Hazard has priority, and both turn requests together also mean hazard.
    function automatic logic [1:0] decode_mode(input logic hazard, input logic left,
                                               input logic right);
        if (hazard || (left && right)) return ST_HAZARD;
        else if (left)                 return ST_LEFT;
        else if (right)                return ST_RIGHT;
        else                           return ST_IDLE;
    endfunction

endpackage

// File: rtl/turn_signal_seq_if.sv
// Request/LED bundle between the panel logic (master) and the sequencer (slave).
interface turn_signal_seq_if #(parameter int LED_W = 8);
    logic             tick_i;
    logic             left_i;
    logic             right_i;
    logic             hazard_i;
    logic [LED_W-1:0] led_left;
    logic [LED_W-1:0] led_right;
    logic [1:0]       state_o;
    logic             active_o;

    modport master (output tick_i, left_i, right_i, hazard_i,
                    input  led_left, led_right, state_o, active_o);
    modport slave  (input  tick_i, left_i, right_i, hazard_i,
                    output led_left, led_right, state_o, active_o);
endinterface

// File: rtl/turn_signal_seq_step_gate.sv
// Tick rising-edge detector plus STEP_TICKS prescaler; step_o pulses on the wrapping edge.
module turn_signal_seq_step_gate #(
    parameter int STEP_TICKS = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic clear,
    output logic step_o
);
    localparam int CNT_W = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;

    logic             tick_q;
    logic [CNT_W-1:0] cnt_q;
    logic             tick_edge;
    logic             cnt_last;

    assign tick_edge = tick & ~tick_q;
    assign cnt_last  = (cnt_q == CNT_W'(STEP_TICKS - 1));
    assign step_o    = tick_edge & cnt_last & ~clear;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tick_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            tick_q <= tick;
            // A clear swallows any edge seen in the same cycle.
            if (clear)
                cnt_q <= '0;
            else if (tick_edge)
                cnt_q <= cnt_last ? '0 : cnt_q + 1'b1;
        end
    end
endmodule

// File: rtl/turn_signal_seq.sv
// Turn-signal sequencer: mode decode, phase counter and registered LED pattern generator.
module turn_signal_seq #(
    parameter int LED_W      = 8,
    parameter int STEP_TICKS = 1
) (
    input logic              clk,
    input logic              rst_n,
    turn_signal_seq_if.slave bus
);
    import turn_signal_seq_pkg::*;

    localparam int PH_W = $clog2(LED_W + 1);

    logic [1:0]       state_q;
    logic [1:0]       mode;
    logic             mode_chg;
    logic             step;
    logic [PH_W-1:0]  phase_q;
    logic [PH_W-1:0]  phase_nxt;
    logic [LED_W-1:0] fill;
    logic [LED_W-1:0] left_nxt;
    logic [LED_W-1:0] right_nxt;
    logic [LED_W-1:0] led_left_q;
    logic [LED_W-1:0] led_right_q;
    logic             active_q;

    assign mode     = decode_mode(bus.hazard_i, bus.left_i, bus.right_i);
    assign mode_chg = (mode != state_q);

    turn_signal_seq_step_gate #(.STEP_TICKS(STEP_TICKS)) u_step_gate (
        .clk    (clk),
        .rst_n  (rst_n),
        .tick   (bus.tick_i),
        .clear  (mode_chg || (state_q == ST_IDLE)),
        .step_o (step)
    );

    always_comb begin
        phase_nxt = phase_q;
        if (mode_chg)
            phase_nxt = '0;
        else if (step) begin
            if (state_q == ST_HAZARD)
                phase_nxt = (phase_q == '0) ? PH_W'(1) : '0;
            else if (phase_q == PH_W'(LED_W))
                phase_nxt = '0;
            else
                phase_nxt = phase_q + 1'b1;
        end
    end

    // Patterns are built from the next phase so the LED registers land with the state.
    always_comb begin
        fill      = '0;
        left_nxt  = '0;
        right_nxt = '0;
        for (int i = 0; i < LED_W; i++)
            fill[i] = (i < int'(phase_nxt));
        case (mode)
            ST_LEFT:   left_nxt = fill;
            ST_RIGHT:
                for (int i = 0; i < LED_W; i++)
                    right_nxt[LED_W-1-i] = fill[i];
            ST_HAZARD: begin
                left_nxt  = {LED_W{phase_nxt[0]}};
                right_nxt = {LED_W{phase_nxt[0]}};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            phase_q     <= '0;
            led_left_q  <= '0;
            led_right_q <= '0;
            active_q    <= 1'b0;
        end else begin
            state_q     <= mode;
            phase_q     <= phase_nxt;
            led_left_q  <= left_nxt;
            led_right_q <= right_nxt;
            active_q    <= (mode != ST_IDLE);
        end
    end

    assign bus.led_left  = led_left_q;
    assign bus.led_right = led_right_q;
    assign bus.state_o   = state_q;
    assign bus.active_o  = active_q;
endmodule
